sigma_delta_dac: RTL

Transmit-side counterpart of the sigma-delta ADC. Accepts signed PCM samples at the decimated rate through a valid/ready handshake and upsamples them by BOSR with a CIC interpolator. A first- or second-order delta-sigma modulator turns the result into a 1-bit PDM stream that drives an output pin and an external RC reconstruction filter.

---
 rtl/sigma_delta_pkg.sv | 18 +
 rtl/sd_modulator.sv | 80 ++++++++
 rtl/sigma_delta_dac.sv | 116 +++++++++++
 3 files changed

// File: rtl/sigma_delta_pkg.sv
// Shared constants and types for the sigma-delta DAC.
// CIC register growth and modulator integrator headroom.
package sigma_delta_pkg;

    localparam int MOD1_HEADROOM = 3;
    localparam int MOD2_HEADROOM = 4;
    localparam int DEF_WDTH      = 16;

    typedef struct packed {
        logic [DEF_WDTH-1:0] data;
        logic                valid;
    } dac_req_t;

    function automatic int cic_growth(input int bosr, input int stages);
        return stages * $clog2(bosr);
    endfunction

endpackage

// File: rtl/sd_modulator.sv
// First- or second-order delta-sigma modulator producing the PDM bit.
// Integrators saturate so an overdriven input can never wrap.
module sd_modulator
    import sigma_delta_pkg::*;
#(
    parameter int MOD_ORDER = 1,
    parameter int WDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic signed [WDTH+1:0] m_i,
    output logic                  pin_o
);

    localparam int HR = (MOD_ORDER == 2) ? MOD2_HEADROOM : MOD1_HEADROOM;
    localparam int AW = WDTH + HR;
    localparam int XW = AW + 2;
    localparam logic signed [XW-1:0] FS   = XW'(2 ** (WDTH - 1));
    localparam logic signed [XW-1:0] AMAX = XW'(2 ** (AW - 1) - 1);
    localparam logic signed [XW-1:0] AMIN = ~AMAX;

    logic              pin_q;
    logic              pos;
    logic signed [XW-1:0] y;
    logic signed [XW-1:0] mx;

    function automatic logic signed [AW-1:0] sat(
        input logic signed [XW-1:0] s
    );
        if (s > AMAX) return AMAX[AW-1:0];
        if (s < AMIN) return AMIN[AW-1:0];
        return s[AW-1:0];
    endfunction

    assign y  = pin_q ? FS : -FS;
    assign mx = XW'(m_i);

    generate
        if (MOD_ORDER == 2) begin : g_o2
            logic signed [AW-1:0] i1_q, i1_d, i2_q, i2_d;

            // i2 integrates the freshly updated i1: NTF (1-z^-1)^2
            always_comb begin
                i1_d = sat(XW'(i1_q) + mx - y);
                i2_d = sat(XW'(i2_q) + XW'(i1_d) - y);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    i1_q <= '0;
                    i2_q <= '0;
                end else begin
                    i1_q <= i1_d;
                    i2_q <= i2_d;
                end
            end

            assign pos = !i2_d[AW-1];
        end else begin : g_o1
            logic signed [AW-1:0] acc_q, acc_d;

            assign acc_d = sat(XW'(acc_q) + mx - y);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) acc_q <= '0;
                else        acc_q <= acc_d;
            end

            assign pos = !acc_d[AW-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pin_q <= 1'b0;
        else        pin_q <= pos;
    end

    assign pin_o = pin_q;

endmodule

// File: rtl/sigma_delta_dac.sv
// PCM-to-PDM DAC: one-entry input buffer, CIC interpolator by BOSR,
// and a delta-sigma modulator driving the output pin.
module sigma_delta_dac
    import sigma_delta_pkg::*;
#(
    parameter int BOSR       = 256,
    parameter int WDTH       = 16,
    parameter int CIC_STAGES = 2,
    parameter int MOD_ORDER  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [WDTH-1:0] dac_input,
    input  logic            dac_valid,
    output logic            dac_ready,
    output logic            dac_pin,
    output logic            dac_underrun
);

    localparam int PW = $clog2(BOSR);
    localparam int IW = WDTH + cic_growth(BOSR, CIC_STAGES);
    localparam int SH = (CIC_STAGES - 1) * PW;
    localparam int MW = WDTH + 2;
    localparam logic [PW-1:0] LAST = PW'(BOSR - 1);

    logic [PW-1:0]   cnt_q;
    logic            tick;
    logic            accept;
    logic [WDTH-1:0] buf_q;
    logic [WDTH-1:0] hold_q;
    logic [WDTH-1:0] smp;
    logic            full_q;
    logic            tick_q;
    logic            urun_q;

    logic signed [IW-1:0] dly_q [CIC_STAGES];
    logic signed [IW-1:0] stg   [CIC_STAGES+1];
    logic signed [IW-1:0] comb_q;
    logic signed [IW-1:0] int_q [CIC_STAGES];
    logic signed [MW-1:0] m;

    assign tick      = (cnt_q == LAST);
    assign accept    = dac_valid && !full_q;
    assign dac_ready = !full_q;
    assign smp       = full_q ? buf_q : hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end

    // An accept on an empty-buffer tick still lands; the tick reuses hold_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            full_q <= 1'b0;
            hold_q <= '0;
            tick_q <= 1'b0;
            urun_q <= 1'b0;
        end else begin
            if (accept) begin
                buf_q  <= dac_input;
                full_q <= 1'b1;
            end else if (tick) begin
                full_q <= 1'b0;
            end
            if (tick) hold_q <= smp;
            tick_q <= tick;
            urun_q <= tick && !full_q;
        end
    end

    always_comb begin
        stg[0] = IW'($signed(smp));
        for (int i = 0; i < CIC_STAGES; i++) begin
            stg[i+1] = stg[i] - dly_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CIC_STAGES; i++) dly_q[i] <= '0;
            comb_q <= '0;
        end else if (tick) begin
            for (int i = 0; i < CIC_STAGES; i++) dly_q[i] <= stg[i];
            comb_q <= stg[CIC_STAGES];
        end
    end

    // Zero-stuffed input: comb_q enters only in the cycle after a tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CIC_STAGES; i++) int_q[i] <= '0;
        end else begin
            int_q[0] <= int_q[0] + (tick_q ? comb_q : '0);
            for (int i = 1; i < CIC_STAGES; i++) begin
                int_q[i] <= int_q[i] + int_q[i-1];
            end
        end
    end

    assign m = int_q[CIC_STAGES-1][SH +: MW];

    sd_modulator #(
        .MOD_ORDER (MOD_ORDER),
        .WDTH      (WDTH)
    ) u_mod (
        .clk   (clk),
        .rst_n (rst_n),
        .m_i   (m),
        .pin_o (dac_pin)
    );

    assign dac_underrun = urun_q;

endmodule
